// File: rtl/spmm_seq_ctrl.sv
// spmm_seq_ctrl: job sequencer for the SpMM datapath.
// It loads the RHS in 4-row beats, streams the CSR LHS beats into the PE array,
// waits out the PE pipeline, and then drains the result in 4-row beats.
// It drives only control: write-enables, beat indices, ready flags and an error flag.
module spmm_seq_ctrl #(
  parameter int N        = 16,  // matrix dimension, multiple of 4, N >= 8
  parameter int PE_DELAY = 2,   // last PE input beat -> valid reduction output
  parameter int MAX_LHS  = N    // LHS beats per job before forced termination
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       rhs_start,
  output logic                       rhs_ready,
  output logic                       rhs_we,
  output logic [$clog2(N/4)-1:0]     rhs_beat,
  input  logic                       keep_rhs,
  output logic                       lhs_ready,
  input  logic                       lhs_start,
  input  logic                       lhs_last,
  output logic                       pe_en,
  output logic                       pe_clear,
  output logic [$clog2(MAX_LHS):0]   lhs_cnt,
  output logic                       out_ready,
  input  logic                       out_start,
  output logic [$clog2(N/4)-1:0]     out_beat,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       err_proto
);

  localparam int BEATS = N / 4;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = $clog2(MAX_LHS) + 1;
  localparam int DW    = $clog2(PE_DELAY) + 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [CW-1:0] LHS_MAX   = CW'(MAX_LHS);
  // The cycle that accepts the last LHS beat counts as the first of the PE_DELAY
  // cycles. DRAIN therefore lasts PE_DELAY-1 cycles, and out_ready rises exactly
  // when the reduction output becomes valid. A PE_DELAY below 2 still spends one
  // cycle in DRAIN.
  localparam logic [DW-1:0] DRAIN_LAST = (PE_DELAY >= 2) ? DW'(PE_DELAY - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_RHS,
    S_WAIT_LHS,
    S_PROC,
    S_DRAIN,
    S_OUT_WAIT,
    S_OUTPUT
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;       // shared by the RHS load and the output drain
  logic [CW-1:0]   lhs_cnt_q, lhs_cnt_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            err_q, err_d;
  logic [CW-1:0]   lhs_cnt_inc;

  assign lhs_cnt_inc = lhs_cnt_q + 1'b1;

  // State and counter registers. An async reset abandons any job in flight.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples its pre-edge value and there are no evaluation-order races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      lhs_cnt_q <= '0;
      drain_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      lhs_cnt_q <= lhs_cnt_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
    end
  end

  // Next-state, counter updates and control-output decode.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    lhs_cnt_d = lhs_cnt_q;
    drain_d   = drain_q;
    err_d     = err_q;
    rhs_ready = 1'b0;
    rhs_we    = 1'b0;
    rhs_beat  = '0;
    lhs_ready = 1'b0;
    pe_en     = 1'b0;
    pe_clear  = 1'b0;
    out_ready = 1'b0;
    out_beat  = '0;
    out_valid = 1'b0;

    // A start strobe that arrives while the FSM is not waiting for it is a
    // protocol violation. The flag is sticky. A stray lhs_start is harmless.
    if (rhs_start && (state_q != S_IDLE))     err_d = 1'b1;
    if (out_start && (state_q != S_OUT_WAIT)) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        rhs_ready = 1'b1;
        if (rhs_start) begin
          rhs_we  = 1'b1;          // beat 0 is written in the start cycle
          beat_d  = BW'(1);
          state_d = S_LOAD_RHS;
        end
      end

      S_LOAD_RHS: begin
        rhs_we   = 1'b1;
        rhs_beat = beat_q;
        if (beat_q == BEAT_LAST) begin
          pe_clear  = 1'b1;        // clear PE state as the last RHS beat is written
          beat_d    = '0;
          lhs_cnt_d = '0;
          state_d   = S_WAIT_LHS;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      // WAIT_LHS always enters with lhs_cnt_q == 0. Accepting its first beat is
      // therefore the same operation as accepting a beat in PROC.
      S_WAIT_LHS, S_PROC: begin
        lhs_ready = 1'b1;
        if (lhs_start) begin
          pe_en     = 1'b1;
          lhs_cnt_d = lhs_cnt_inc;
          if (lhs_last) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end else if (lhs_cnt_inc == LHS_MAX) begin
            err_d   = 1'b1;        // runaway job: force termination
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            state_d = S_PROC;
          end
        end
      end

      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = S_OUT_WAIT;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      S_OUT_WAIT: begin
        out_ready = 1'b1;
        if (out_start) begin
          beat_d  = '0;
          state_d = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        out_valid = 1'b1;
        out_beat  = beat_q;
        if (beat_q == BEAT_LAST) begin
          beat_d    = '0;
          lhs_cnt_d = '0;
          if (keep_rhs) begin
            pe_clear = 1'b1;       // the RHS stays resident; only PE state is reset
            state_d  = S_WAIT_LHS;
          end else begin
            state_d  = S_IDLE;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign lhs_cnt   = lhs_cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign err_proto = err_q;

endmodule

// File: tb/tb_spmm_seq_ctrl.sv
// tb_spmm_seq_ctrl: directed, table-driven bench for spmm_seq_ctrl (N=16, PE_DELAY=2).
// Each table record holds one cycle of inputs and the outputs expected in that cycle.
// Inputs are driven on the falling edge, and outputs are compared 2 ns later,
// ahead of the next rising edge.
module tb_spmm_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rhs_start, keep_rhs, lhs_start, lhs_last, out_start;
  logic       rhs_ready, rhs_we, lhs_ready, pe_en, pe_clear;
  logic [1:0] rhs_beat, out_beat;
  logic [4:0] lhs_cnt;
  logic       out_ready, out_valid, busy, err_proto;

  always #5 clock = ~clock;

  spmm_seq_ctrl #(.N(16), .PE_DELAY(2), .MAX_LHS(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rhs_start (rhs_start),
    .rhs_ready (rhs_ready),
    .rhs_we    (rhs_we),
    .rhs_beat  (rhs_beat),
    .keep_rhs  (keep_rhs),
    .lhs_ready (lhs_ready),
    .lhs_start (lhs_start),
    .lhs_last  (lhs_last),
    .pe_en     (pe_en),
    .pe_clear  (pe_clear),
    .lhs_cnt   (lhs_cnt),
    .out_ready (out_ready),
    .out_start (out_start),
    .out_beat  (out_beat),
    .out_valid (out_valid),
    .busy      (busy),
    .err_proto (err_proto)
  );

  typedef struct packed {
    logic       rhs_ready;
    logic       rhs_we;
    logic [1:0] rhs_beat;
    logic       lhs_ready;
    logic       pe_en;
    logic       pe_clear;
    logic [4:0] lhs_cnt;
    logic       out_ready;
    logic [1:0] out_beat;
    logic       out_valid;
    logic       busy;
    logic       err;
  } outs_t;

  // Input bits, in order: {rhs_start, keep_rhs, lhs_start, lhs_last, out_start}.
  typedef struct {
    string      name;
    logic [4:0] in;
    outs_t      exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t act;
  int    n_vec = 0;
  int    n_bad = 0;

  assign act = {rhs_ready, rhs_we, rhs_beat, lhs_ready, pe_en, pe_clear,
                lhs_cnt, out_ready, out_beat, out_valid, busy, err_proto};

  function automatic outs_t eo(int rr, int we, int rb, int lr, int pe, int pc,
                               int lc, int orr, int ob, int ov, int bz, int er);
    outs_t e;
    e.rhs_ready = 1'(rr);
    e.rhs_we    = 1'(we);
    e.rhs_beat  = 2'(rb);
    e.lhs_ready = 1'(lr);
    e.pe_en     = 1'(pe);
    e.pe_clear  = 1'(pc);
    e.lhs_cnt   = 5'(lc);
    e.out_ready = 1'(orr);
    e.out_beat  = 2'(ob);
    e.out_valid = 1'(ov);
    e.busy      = 1'(bz);
    e.err       = 1'(er);
    return e;
  endfunction

  task automatic add(input string name, input logic [4:0] in, input outs_t e);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] in);
    @(negedge clock);
    {rhs_start, keep_rhs, lhs_start, lhs_last, out_start} = in;
    #2;
  endtask

  task automatic check(input string name, input outs_t e);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %05h want %05h (lhs_cnt got %0d want %0d)",
               name, act, e, act.lhs_cnt, e.lhs_cnt);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    {rhs_start, keep_rhs, lhs_start, lhs_last, out_start} = 5'b00000;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic build_table();
    // Job 1: full load, 5 back-to-back LHS beats, drain, output, keep_rhs=1.
    add("j1_reset",  5'b00000, eo(1,0,0,0,0,0,0,0,0,0,0,0));
    add("j1_rhs0",   5'b10000, eo(1,1,0,0,0,0,0,0,0,0,0,0));
    add("j1_rhs1",   5'b00000, eo(0,1,1,0,0,0,0,0,0,0,1,0));
    add("j1_rhs2",   5'b00000, eo(0,1,2,0,0,0,0,0,0,0,1,0));
    add("j1_rhs3",   5'b00000, eo(0,1,3,0,0,1,0,0,0,0,1,0));
    add("j1_wait",   5'b00000, eo(0,0,0,1,0,0,0,0,0,0,1,0));
    add("j1_lhs1",   5'b00100, eo(0,0,0,1,1,0,0,0,0,0,1,0));
    add("j1_lhs2",   5'b00100, eo(0,0,0,1,1,0,1,0,0,0,1,0));
    add("j1_lhs3",   5'b00100, eo(0,0,0,1,1,0,2,0,0,0,1,0));
    add("j1_lhs4",   5'b00100, eo(0,0,0,1,1,0,3,0,0,0,1,0));
    add("j1_lhs5",   5'b00110, eo(0,0,0,1,1,0,4,0,0,0,1,0));
    add("j1_drain",  5'b00000, eo(0,0,0,0,0,0,5,0,0,0,1,0));
    add("j1_ordy",   5'b00000, eo(0,0,0,0,0,0,5,1,0,0,1,0));
    add("j1_ostart", 5'b00001, eo(0,0,0,0,0,0,5,1,0,0,1,0));
    add("j1_out0",   5'b00000, eo(0,0,0,0,0,0,5,0,0,1,1,0));
    add("j1_out1",   5'b00000, eo(0,0,0,0,0,0,5,0,1,1,1,0));
    add("j1_out2",   5'b00000, eo(0,0,0,0,0,0,5,0,2,1,1,0));
    add("j1_out3",   5'b01000, eo(0,0,0,0,0,1,5,0,3,1,1,0));
    // Job 2 reuses the RHS: no rhs_we, and a single beat carrying lhs_last.
    add("j2_wait",   5'b00000, eo(0,0,0,1,0,0,0,0,0,0,1,0));
    add("j2_lhs1",   5'b00110, eo(0,0,0,1,1,0,0,0,0,0,1,0));
    add("j2_drain",  5'b00000, eo(0,0,0,0,0,0,1,0,0,0,1,0));
    add("j2_ordy",   5'b00000, eo(0,0,0,0,0,0,1,1,0,0,1,0));
    add("j2_ostart", 5'b00001, eo(0,0,0,0,0,0,1,1,0,0,1,0));
    add("j2_out0",   5'b00000, eo(0,0,0,0,0,0,1,0,0,1,1,0));
    add("j2_out1",   5'b00000, eo(0,0,0,0,0,0,1,0,1,1,1,0));
    add("j2_out2",   5'b00000, eo(0,0,0,0,0,0,1,0,2,1,1,0));
    add("j2_out3",   5'b00000, eo(0,0,0,0,0,0,1,0,3,1,1,0));
    add("j2_idle",   5'b00000, eo(1,0,0,0,0,0,0,0,0,0,0,0));
    // Job 3: bubbles, lhs_last without lhs_start, and a stray lhs_start in OUT_WAIT.
    add("j3_rhs0",   5'b10000, eo(1,1,0,0,0,0,0,0,0,0,0,0));
    add("j3_rhs1",   5'b00000, eo(0,1,1,0,0,0,0,0,0,0,1,0));
    add("j3_rhs2",   5'b00000, eo(0,1,2,0,0,0,0,0,0,0,1,0));
    add("j3_rhs3",   5'b00000, eo(0,1,3,0,0,1,0,0,0,0,1,0));
    add("j3_lhs1",   5'b00100, eo(0,0,0,1,1,0,0,0,0,0,1,0));
    add("j3_bub1",   5'b00000, eo(0,0,0,1,0,0,1,0,0,0,1,0));
    add("j3_bub2",   5'b00010, eo(0,0,0,1,0,0,1,0,0,0,1,0));
    add("j3_lhs2",   5'b00100, eo(0,0,0,1,1,0,1,0,0,0,1,0));
    add("j3_lhs3",   5'b00110, eo(0,0,0,1,1,0,2,0,0,0,1,0));
    add("j3_drain",  5'b00000, eo(0,0,0,0,0,0,3,0,0,0,1,0));
    add("j3_ordy",   5'b00100, eo(0,0,0,0,0,0,3,1,0,0,1,0));
    add("j3_ostart", 5'b00001, eo(0,0,0,0,0,0,3,1,0,0,1,0));
    add("j3_out0",   5'b00000, eo(0,0,0,0,0,0,3,0,0,1,1,0));
    add("j3_out1",   5'b00000, eo(0,0,0,0,0,0,3,0,1,1,1,0));
    add("j3_out2",   5'b00000, eo(0,0,0,0,0,0,3,0,2,1,1,0));
    add("j3_out3",   5'b01000, eo(0,0,0,0,0,1,3,0,3,1,1,0));
    // Job 4: rhs_start in PROC and out_start in DRAIN are ignored; the job completes.
    add("j4_lhs1",   5'b00100, eo(0,0,0,1,1,0,0,0,0,0,1,0));
    add("j4_rhsbad", 5'b10100, eo(0,0,0,1,1,0,1,0,0,0,1,0));
    add("j4_lhs3",   5'b00110, eo(0,0,0,1,1,0,2,0,0,0,1,1));
    add("j4_outbad", 5'b00001, eo(0,0,0,0,0,0,3,0,0,0,1,1));
    add("j4_ordy",   5'b00000, eo(0,0,0,0,0,0,3,1,0,0,1,1));
    add("j4_ostart", 5'b00001, eo(0,0,0,0,0,0,3,1,0,0,1,1));
    add("j4_out0",   5'b00000, eo(0,0,0,0,0,0,3,0,0,1,1,1));
    add("j4_out1",   5'b00000, eo(0,0,0,0,0,0,3,0,1,1,1,1));
    add("j4_out2",   5'b00000, eo(0,0,0,0,0,0,3,0,2,1,1,1));
    add("j4_out3",   5'b00000, eo(0,0,0,0,0,0,3,0,3,1,1,1));
    add("j4_idle",   5'b00000, eo(1,0,0,0,0,0,0,0,0,0,0,1));
  endtask

  initial begin
    reset_n = 1'b0;
    {rhs_start, keep_rhs, lhs_start, lhs_last, out_start} = 5'b00000;
    build_table();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      check($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].exp);
    end

    // Reset in the middle of PROC with lhs_cnt=7, then ignored strobes in IDLE.
    do_reset();
    drive(5'b10000);
    check("rst_rhs0", eo(1,1,0,0,0,0,0,0,0,0,0,0));
    drive(5'b00000);
    drive(5'b00000);
    drive(5'b00000);
    for (int i = 0; i < 7; i++) begin
      drive(5'b00100);
      check($sformatf("rst_lhs%0d", i), eo(0,0,0,1,1,0,i,0,0,0,1,0));
    end
    drive(5'b00100);
    check("rst_proc_lc7", eo(0,0,0,1,1,0,7,0,0,0,1,0));
    #1 reset_n = 1'b0;
    #1 check("rst_async_idle", eo(1,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clock);
    reset_n = 1'b1;
    drive(5'b00100);
    check("rst_lhs_ignored", eo(1,0,0,0,0,0,0,0,0,0,0,0));
    drive(5'b00001);
    check("idle_ostart_cyc", eo(1,0,0,0,0,0,0,0,0,0,0,0));
    drive(5'b00000);
    check("idle_ostart_err", eo(1,0,0,0,0,0,0,0,0,0,0,1));

    // 16 beats without lhs_last force DRAIN and set a sticky err_proto.
    do_reset();
    drive(5'b10000);
    drive(5'b00000);
    drive(5'b00000);
    drive(5'b00000);
    for (int i = 0; i < 16; i++) begin
      drive(5'b00100);
      check($sformatf("max_lhs%0d", i), eo(0,0,0,1,1,0,i,0,0,0,1,0));
    end
    drive(5'b00000);
    check("max_forced_drain", eo(0,0,0,0,0,0,16,0,0,0,1,1));
    drive(5'b00000);
    check("max_ordy", eo(0,0,0,0,0,0,16,1,0,0,1,1));
    drive(5'b00001);
    drive(5'b00000);
    drive(5'b00000);
    drive(5'b00000);
    drive(5'b01000);
    check("max_out3_keep", eo(0,0,0,0,0,1,16,0,3,1,1,1));
    drive(5'b00110);
    check("max_next_lhs", eo(0,0,0,1,1,0,0,0,0,0,1,1));
    drive(5'b00000);
    check("max_next_drain", eo(0,0,0,0,0,0,1,0,0,0,1,1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
